// File: rtl/bcd_score_counter.sv
// Parametrised packed-BCD game score counter with wrap/saturate,
// bonus injection, milestone/overflow pulses and a high-score register.
module bcd_score_counter #(
    parameter int DIGITS          = 5,
    parameter int WRAP            = 1,
    parameter int BONUS_DIGIT     = 1,
    parameter int MILESTONE_DIGIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_start,
    input  logic                  game_frozen,
    input  logic                  game_tick,
    input  logic                  bonus_valid,
    input  logic [3:0]            bonus_value,
    input  logic                  game_over,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  new_high,
    output logic                  milestone,
    output logic                  overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int MS = 4 * MILESTONE_DIGIT;
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

    logic [W-1:0] score_q, score_d, high_q, sum;
    logic         new_high_q, milestone_q, overflow_q;
    logic [3:0]   bv;
    logic [4:0]   t;
    logic         add_en, carry, cout;

    // Tick enters as the carry-in of digit 0, so each digit sees at most 9+9+1.
    always_comb begin
        bv     = (bonus_value > 4'd9) ? 4'd9 : bonus_value;
        add_en = !game_frozen && (game_tick || (bonus_valid && bv != 4'd0));
        carry  = game_tick;
        sum    = '0;
        t      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, score_q[4*i +: 4]} + {4'b0, carry};
            if (bonus_valid && i == BONUS_DIGIT)
                t = t + {1'b0, bv};
            if (t > 5'd9) begin
                t     = t - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = t[3:0];
        end
        cout    = carry;
        score_d = (cout && WRAP == 0) ? ALL9 : sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q     <= '0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            milestone_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            new_high_q  <= 1'b0;
            milestone_q <= 1'b0;
            overflow_q  <= 1'b0;
            // Compare always uses the pre-add / pre-clear score.
            if (game_over && score_q > high_q) begin
                high_q     <= score_q;
                new_high_q <= 1'b1;
            end
            if (game_start) begin
                score_q <= '0;
            end else if (add_en) begin
                score_q     <= score_d;
                overflow_q  <= cout;
                milestone_q <= score_d[W-1:MS] != score_q[W-1:MS];
            end
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign milestone  = milestone_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter: a wrapping and a
// saturating instance driven by the same stimulus.
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        rst, game_start, game_frozen, game_tick;
    logic        bonus_valid, game_over;
    logic [3:0]  bonus_value;
    logic [19:0] score, high_score, score_s, high_score_s;
    logic        new_high, milestone, overflow;
    logic        new_high_s, milestone_s, overflow_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_score_counter #(.DIGITS(5), .WRAP(1), .BONUS_DIGIT(1),
                        .MILESTONE_DIGIT(2)) dut (
        .clk(clk), .rst(rst), .game_start(game_start),
        .game_frozen(game_frozen), .game_tick(game_tick),
        .bonus_valid(bonus_valid), .bonus_value(bonus_value),
        .game_over(game_over), .score(score), .high_score(high_score),
        .new_high(new_high), .milestone(milestone), .overflow(overflow)
    );

    bcd_score_counter #(.DIGITS(5), .WRAP(0), .BONUS_DIGIT(1),
                        .MILESTONE_DIGIT(2)) dut_sat (
        .clk(clk), .rst(rst), .game_start(game_start),
        .game_frozen(game_frozen), .game_tick(game_tick),
        .bonus_valid(bonus_valid), .bonus_value(bonus_value),
        .game_over(game_over), .score(score_s),
        .high_score(high_score_s), .new_high(new_high_s),
        .milestone(milestone_s), .overflow(overflow_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        game_start  = 1'b0;
        game_tick   = 1'b0;
        bonus_valid = 1'b0;
        bonus_value = 4'd0;
        game_over   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            game_tick = 1'b1;
            cyc();
        end
    endtask

    task automatic bonus(input logic [3:0] v, input logic tk);
        bonus_valid = 1'b1;
        bonus_value = v;
        game_tick   = tk;
        cyc();
    endtask

    initial begin
        rst = 1'b0; game_start = 1'b0; game_frozen = 1'b0;
        game_tick = 1'b0; bonus_valid = 1'b0; bonus_value = 4'd0;
        game_over = 1'b0;
        #2;

        rst = 1'b1;
        cyc();
        chk("rst_score", score, 20'h00000);
        chk("rst_high", high_score, 20'h00000);
        chk("rst_pulses", {new_high, milestone, overflow}, 3'b000);

        ticks(12);
        chk("count12", score, 20'h00012);

        rst = 1'b1;
        game_tick = 1'b1;
        cyc();
        chk("midrst_score", score, 20'h00000);
        chk("midrst_pulses", {new_high, milestone, overflow}, 3'b000);

        ticks(99);
        chk("load99", score, 20'h00099);
        ticks(1);
        chk("ripple100", score, 20'h00100);
        chk("ms_100", milestone, 1'b1);
        ticks(1);
        chk("score101", score, 20'h00101);
        chk("ms_101", milestone, 1'b0);

        game_start = 1'b1;
        cyc();
        bonus(4'd9, 1'b0);
        chk("bonus90", score, 20'h00090);
        chk("ms_90", milestone, 1'b0);
        ticks(5);
        bonus(4'd7, 1'b1);
        chk("bonus_tick", score, 20'h00166);
        chk("ms_166", milestone, 1'b1);
        bonus(4'hC, 1'b0);
        chk("bonus_clamp", score, 20'h00256);

        game_frozen = 1'b1;
        ticks(5);
        chk("frozen", score, 20'h00256);
        game_frozen = 1'b0;

        game_tick  = 1'b1;
        game_start = 1'b1;
        cyc();
        chk("start_prio", score, 20'h00000);
        chk("start_no_ms", milestone, 1'b0);

        bonus(4'd9, 1'b0);
        bonus(4'd6, 1'b0);
        chk("score150", score, 20'h00150);
        game_over = 1'b1;
        cyc();
        chk("high150", high_score, 20'h00150);
        chk("nh_150", new_high, 1'b1);
        cyc();
        chk("nh_clear", new_high, 1'b0);

        game_start = 1'b1;
        cyc();
        bonus(4'd9, 1'b0);
        bonus(4'd3, 1'b0);
        chk("score120", score, 20'h00120);
        game_over = 1'b1;
        cyc();
        chk("high_keep", high_score, 20'h00150);
        chk("nh_none", new_high, 1'b0);

        bonus(4'd3, 1'b1);
        chk("score151", score, 20'h00151);
        game_over  = 1'b1;
        game_start = 1'b1;
        cyc();
        chk("high151", high_score, 20'h00151);
        chk("nh_151", new_high, 1'b1);
        chk("over_clear", score, 20'h00000);

        for (int i = 0; i < 1111; i++)
            bonus(4'd9, 1'b0);
        ticks(9);
        chk("wrap_99999", score, 20'h99999);
        chk("sat_99999", score_s, 20'h99999);
        ticks(1);
        chk("wrap_zero", score, 20'h00000);
        chk("wrap_ov", overflow, 1'b1);
        chk("wrap_ms", milestone, 1'b1);
        chk("sat_hold", score_s, 20'h99999);
        chk("sat_ov", overflow_s, 1'b1);
        ticks(1);
        chk("wrap_one", score, 20'h00001);
        chk("wrap_ov_clr", overflow, 1'b0);
        chk("sat_hold2", score_s, 20'h99999);
        chk("sat_ov2", overflow_s, 1'b1);
        bonus(4'd0, 1'b0);
        chk("sat_zero_add", overflow_s, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
- Parametrised BCD game-score counter; successor to the fixed 5-digit score counter.
- Adds configurable digit count, wrap/saturate mode, bonus-point injection, milestone and overflow pulses, and a high-score register.
- Sits between the game-state controller (start/frozen/over/tick) and the score/high-score display renderer.

Parameters:
DIGITS, 5, number of BCD digits; score width = 4*DIGITS; legal range 2..8
WRAP, 1, 1 = wrap to zero past all-9s; 0 = saturate at all-9s
BONUS_DIGIT, 1, digit index that bonus_value is added into (0 = ones); must be < DIGITS
MILESTONE_DIGIT, 2, milestone fires when the value of digits [DIGITS-1:MILESTONE_DIGIT] changes; must be < DIGITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
game_start  in  1  one-cycle pulse; clears score for a new game
game_frozen  in  1  level; when high, tick and bonus are ignored
game_tick  in  1  one-cycle end-of-frame pulse (60 Hz); adds 1 point
bonus_valid  in  1  one-cycle pulse; adds bonus_value at BONUS_DIGIT
bonus_value  in  4  BCD bonus digit 0..9; codes 10..15 clamp to 9
game_over  in  1  one-cycle pulse; triggers high-score compare
score  out  4*DIGITS  current score, packed BCD, digit 0 in [3:0]
high_score  out  4*DIGITS  best score since rst, packed BCD
new_high  out  1  one-cycle pulse: high_score updated
milestone  out  1  one-cycle pulse: upper digits changed
overflow  out  1  one-cycle pulse: add carried out of top digit

Behaviour:
- Single clock domain, all state updates on posedge clk. All outputs are registered. Each output reflects the event inputs sampled on the previous edge: 1-cycle latency.
- rst (synchronous, highest priority): score = 0, high_score = 0, new_high = 0, milestone = 0, overflow = 0.
- Addend: A = (game_tick ? 1 : 0) + (bonus_valid ? clamp(bonus_value) * 10^BONUS_DIGIT : 0). Applied only when game_frozen = 0 and A != 0.
- Tick and bonus in the same cycle are applied as a single add.
- Arithmetic: digit-serial BCD add with decimal carry ripple, completed in one cycle. Every score digit stays within 0..9 at all times.
- Carry out of digit DIGITS-1:
  - WRAP=1: score = sum mod 10^DIGITS; overflow pulses.
  - WRAP=0: score = all 9s; overflow pulses.
  - If score is already all 9s and WRAP=0, any nonzero add re-pulses overflow and the score holds.
- milestone pulses when score[4*DIGITS-1:4*MILESTONE_DIGIT] differs before and after an add. This includes wrap to 0. It does not fire on game_start clear.
- game_start (no rst): score = 0; milestone = 0; overflow = 0; tick and bonus that cycle are discarded.
- game_start has priority over tick and bonus. high_score is not cleared by game_start.
- game_over: if score > high_score (unsigned compare of the packed BCD vectors, valid because BCD is order-preserving), then high_score <= score and new_high pulses. Otherwise nothing changes. The compare uses the score register value before any same-cycle add or clear.
- game_over together with game_start: the compare uses the pre-clear score, and the clear also happens.
- game_over together with tick: the compare uses the pre-add score, and the add also happens.
- Frozen: game_frozen = 1 blocks the add only. game_start and game_over still act.
- Pulse outputs are deasserted in every cycle without their event; they never stretch.

Test Plan:
- Reset/count: rst, then 12 ticks → score = 0x00012; rst mid-count → all outputs 0 on the next cycle.
- Carry ripple: load 00099 via 99 ticks, 1 tick → 00100, milestone pulse (MILESTONE_DIGIT=2); 1 more tick → 00101, no milestone.
- Bonus + tick same cycle: score 00095, bonus_value = 7 and tick together (BONUS_DIGIT=1) → 00166, milestone pulse; bonus_value = 0xC → treated as 9.
- Overflow:
  - WRAP=1: score 99999 + tick → 00000, overflow and milestone pulse.
  - WRAP=0: 99999 + tick → 99999, overflow pulse; a further tick → overflow pulses again.
- Frozen/start priority: game_frozen = 1 with 5 ticks → score unchanged; tick + game_start same cycle → score 0, no milestone.
- High score:
  - score 00150, game_over → high_score = 00150, new_high pulse.
  - game_start, reach 00120, game_over → high_score stays 00150, no pulse.
  - Reach 00151 and assert game_over + game_start together → high_score = 00151, score = 0.
